// File: rtl/vibe_pattern_ctrl.sv
// Haptic burst sequencer: plays N on/off bursts as 1-cycle shake_open/shake_close pulses.
// Optional feature macro: VIBE_RETRIGGER_EN (start while busy restarts the pattern).
module vibe_pattern_ctrl #(
    parameter int unsigned MS_DIV     = 50000,
    parameter int unsigned ON_MS      = 200,
    parameter int unsigned LONG_ON_MS = 600,
    parameter int unsigned OFF_MS     = 100
) (
    input  logic       clk_50M,
    input  logic       s_rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] burst_cnt,
    input  logic       long_sel,
    output logic       shake_open,
    output logic       shake_close,
    output logic       busy,
    output logic       done
);

    localparam int unsigned PRESC_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int unsigned MS_W    = 16;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [MS_W-1:0]    ms_q, ms_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [MS_W-1:0]    on_ms_q, on_ms_d;
    logic               shake_open_q, shake_open_d;
    logic               shake_close_q, shake_close_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               tick_c;
    logic [MS_W-1:0]    phase_len_c;
    logic               phase_end_c;
    logic [MS_W-1:0]    load_on_ms_c;
    logic               retrig_c;

`ifdef VIBE_RETRIGGER_EN
    assign retrig_c = start;
`else
    assign retrig_c = 1'b0;
`endif

    // Timebase: phase ends on the last prescaler cycle of the last ms of the phase.
    assign tick_c       = (presc_q == PRESC_W'(MS_DIV - 1));
    assign phase_len_c  = (state_q == S_ON) ? on_ms_q : MS_W'(OFF_MS);
    assign phase_end_c  = tick_c && (ms_q == (phase_len_c - MS_W'(1)));
    assign load_on_ms_c = long_sel ? MS_W'(LONG_ON_MS) : MS_W'(ON_MS);

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        on_ms_d       = on_ms_q;
        shake_open_d  = 1'b0;
        shake_close_d = 1'b0;
        done_d        = 1'b0;
        presc_d       = tick_c ? '0 : (presc_q + PRESC_W'(1));
        ms_d          = tick_c ? (ms_q + MS_W'(1)) : ms_q;

        case (state_q)
            S_IDLE: begin
                presc_d = '0;
                ms_d    = '0;
                if (start && !stop && (burst_cnt != '0)) begin
                    state_d      = S_ON;
                    remaining_d  = burst_cnt;
                    on_ms_d      = load_on_ms_c;
                    shake_open_d = 1'b1;
                end
            end
            default: begin
                // Abort (stop, or a retrigger with zero bursts) beats retrigger beats expiry.
                if (stop || (retrig_c && (burst_cnt == '0))) begin
                    state_d       = S_IDLE;
                    shake_close_d = 1'b1;
                    presc_d       = '0;
                    ms_d          = '0;
                end else if (retrig_c) begin
                    state_d      = S_ON;
                    remaining_d  = burst_cnt;
                    on_ms_d      = load_on_ms_c;
                    shake_open_d = 1'b1;
                    presc_d      = '0;
                    ms_d         = '0;
                end else if (phase_end_c) begin
                    presc_d = '0;
                    ms_d    = '0;
                    if (state_q == S_ON) begin
                        shake_close_d = 1'b1;
                        remaining_d   = remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_OFF;
                        end
                    end else begin
                        state_d      = S_ON;
                        shake_open_d = 1'b1;
                    end
                end
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_50M) begin
        if (!s_rst_n) begin
            state_q       <= S_IDLE;
            presc_q       <= '0;
            ms_q          <= '0;
            remaining_q   <= '0;
            on_ms_q       <= '0;
            shake_open_q  <= 1'b0;
            shake_close_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            ms_q          <= ms_d;
            remaining_q   <= remaining_d;
            on_ms_q       <= on_ms_d;
            shake_open_q  <= shake_open_d;
            shake_close_q <= shake_close_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign shake_open  = shake_open_q;
    assign shake_close = shake_close_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_vibe_pattern_ctrl.sv
// Self-checking bench for vibe_pattern_ctrl; reference model tracks absolute phase deadlines.
module tb_vibe_pattern_ctrl;

    localparam int unsigned MS_DIV     = 10;
    localparam int unsigned ON_MS      = 3;
    localparam int unsigned LONG_ON_MS = 5;
    localparam int unsigned OFF_MS     = 2;
`ifdef VIBE_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic       clk_50M = 1'b0;
    logic       s_rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] burst_cnt = 4'd0;
    logic       long_sel = 1'b0;
    logic       shake_open, shake_close, busy, done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    bit m_busy = 0;
    bit m_on   = 0;
    int m_rem  = 0;
    int m_onlen = 0;
    int m_deadline = 0;
    bit e_open = 0, e_close = 0, e_done = 0, e_busy = 0;

    vibe_pattern_ctrl #(
        .MS_DIV    (MS_DIV),
        .ON_MS     (ON_MS),
        .LONG_ON_MS(LONG_ON_MS),
        .OFF_MS    (OFF_MS)
    ) dut (
        .clk_50M    (clk_50M),
        .s_rst_n    (s_rst_n),
        .start      (start),
        .stop       (stop),
        .burst_cnt  (burst_cnt),
        .long_sel   (long_sel),
        .shake_open (shake_open),
        .shake_close(shake_close),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk_50M = ~clk_50M;

    // Advance one clock and update the model from the inputs sampled on that edge.
    task automatic step();
        @(posedge clk_50M);
        cyc++;
        e_open = 0; e_close = 0; e_done = 0;
        if (!s_rst_n) begin
            m_busy = 0;
        end else if (!m_busy) begin
            if (start && !stop && burst_cnt != 0) begin
                m_busy = 1; m_on = 1; m_rem = int'(burst_cnt);
                m_onlen = long_sel ? LONG_ON_MS : ON_MS;
                m_deadline = cyc + m_onlen * MS_DIV;
                e_open = 1;
            end
        end else if (stop) begin
            e_close = 1; m_busy = 0;
        end else if (RETRIG && start) begin
            if (burst_cnt == 0) begin
                e_close = 1; m_busy = 0;
            end else begin
                m_on = 1; m_rem = int'(burst_cnt);
                m_onlen = long_sel ? LONG_ON_MS : ON_MS;
                m_deadline = cyc + m_onlen * MS_DIV;
                e_open = 1;
            end
        end else if (cyc == m_deadline) begin
            if (m_on) begin
                e_close = 1; m_rem--;
                if (m_rem == 0) begin
                    e_done = 1; m_busy = 0;
                end else begin
                    m_on = 0; m_deadline = cyc + OFF_MS * MS_DIV;
                end
            end else begin
                e_open = 1; m_on = 1; m_deadline = cyc + m_onlen * MS_DIV;
            end
        end
        e_busy = m_busy;
        #1;
    endtask

    task automatic test_reset();
        s_rst_n = 0; start = 1; burst_cnt = 4'd3;
        repeat (5) begin
            step();
            total++;
            if ({shake_open, shake_close, done, busy} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=0000", cyc, {shake_open, shake_close, done, busy});
            end
        end
        start = 0; burst_cnt = 0; s_rst_n = 1;
        repeat (3) begin
            step();
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_release_busy cyc=%0d got=%b exp=0", cyc, busy);
            end
        end
    endtask

    task automatic test_two_bursts();
        int t0, c1, o2, d1;
        c1 = -1; o2 = -1; d1 = -1;
        start = 1; burst_cnt = 4'd2; long_sel = 0;
        step();
        start = 0;
        t0 = cyc;
        total++;
        if (shake_open !== 1'b1) begin
            bad++;
            $display("FAIL two_first_open cyc=%0d got=%b exp=1", cyc, shake_open);
        end
        repeat (100) begin
            step();
            total++;
            if ({shake_open, shake_close, done, busy} !== {e_open, e_close, e_done, e_busy}) begin
                bad++;
                $display("FAIL two_trace cyc=%0d got=%b exp=%b", cyc,
                         {shake_open, shake_close, done, busy}, {e_open, e_close, e_done, e_busy});
            end
            if (shake_close === 1'b1 && c1 < 0) c1 = cyc;
            if (shake_open === 1'b1 && o2 < 0) o2 = cyc;
            if (done === 1'b1 && d1 < 0) d1 = cyc;
        end
        total++;
        if (c1 != t0 + 30) begin bad++; $display("FAIL two_close1 got=%0d exp=%0d", c1 - t0, 30); end
        total++;
        if (o2 != t0 + 50) begin bad++; $display("FAIL two_open2 got=%0d exp=%0d", o2 - t0, 50); end
        total++;
        if (d1 != t0 + 80) begin bad++; $display("FAIL two_done got=%0d exp=%0d", d1 - t0, 80); end
    endtask

    task automatic test_zero_burst();
        int pulses;
        pulses = 0;
        start = 1; burst_cnt = 4'd0;
        step();
        start = 0;
        repeat (200) begin
            step();
            if (shake_open === 1'b1 || shake_close === 1'b1 || done === 1'b1 || busy !== 1'b0) pulses++;
        end
        total++;
        if (pulses != 0) begin bad++; $display("FAIL zero_burst activity got=%0d exp=0", pulses); end
    endtask

    task automatic test_start_stop_same();
        int act;
        act = 0;
        start = 1; stop = 1; burst_cnt = 4'd2;
        step();
        start = 0; stop = 0;
        repeat (5) begin
            step();
            if (shake_open === 1'b1 || busy !== 1'b0) act++;
        end
        total++;
        if (act != 0) begin bad++; $display("FAIL start_stop_same activity got=%0d exp=0", act); end
    endtask

    task automatic test_stop();
        int t0, ndone;
        ndone = 0;
        start = 1; burst_cnt = 4'd3; long_sel = 1;
        step();
        start = 0; long_sel = 0;
        t0 = cyc;
        repeat (10) step();
        stop = 1;
        step();
        stop = 0;
        total++;
        if ({shake_open, shake_close, done, busy} !== 4'b0100 || cyc != t0 + 11) begin
            bad++;
            $display("FAIL stop_close cyc=%0d got=%b exp=0100", cyc - t0, {shake_open, shake_close, done, busy});
        end
        repeat (100) begin
            step();
            if (done === 1'b1 || busy === 1'b1 || shake_open === 1'b1) ndone++;
        end
        total++;
        if (ndone != 0) begin bad++; $display("FAIL stop_after got=%0d exp=0", ndone); end
    endtask

    task automatic test_retrigger();
        int t0, o2, d1;
        o2 = -1; d1 = -1;
        start = 1; burst_cnt = 4'd2; long_sel = 0;
        step();
        t0 = cyc;
        start = 0;
        repeat (5) step();
        start = 1; burst_cnt = 4'd1;
        step();
        start = 0;
        if (shake_open === 1'b1) o2 = cyc;
        repeat (100) begin
            step();
            total++;
            if ({shake_open, shake_close, done, busy} !== {e_open, e_close, e_done, e_busy}) begin
                bad++;
                $display("FAIL retrig_trace cyc=%0d got=%b exp=%b", cyc - t0,
                         {shake_open, shake_close, done, busy}, {e_open, e_close, e_done, e_busy});
            end
            if (done === 1'b1 && d1 < 0) d1 = cyc;
        end
        total++;
        if (RETRIG) begin
            if (o2 != t0 + 6 || d1 != t0 + 36) begin
                bad++;
                $display("FAIL retrig_timing open=%0d done=%0d exp open=6 done=36", o2 - t0, d1 - t0);
            end
        end else begin
            if (o2 != -1 || d1 != t0 + 80) begin
                bad++;
                $display("FAIL retrig_ignored open=%0d done=%0d exp open=none done=80", o2, d1 - t0);
            end
        end
    endtask

    task automatic test_reset_mid();
        int ndone, act;
        ndone = 0; act = 0;
        start = 1; burst_cnt = 4'd2;
        step();
        start = 0;
        repeat (15) step();
        s_rst_n = 0;
        repeat (3) begin
            step();
            if ({shake_open, shake_close, done, busy} !== 4'b0000) act++;
        end
        total++;
        if (act != 0) begin bad++; $display("FAIL reset_mid_outputs got=%0d exp=0", act); end
        s_rst_n = 1;
        step();
        start = 1; burst_cnt = 4'd1;
        step();
        start = 0;
        repeat (60) begin
            step();
            total++;
            if ({shake_open, shake_close, done, busy} !== {e_open, e_close, e_done, e_busy}) begin
                bad++;
                $display("FAIL reset_mid_trace cyc=%0d got=%b exp=%b", cyc,
                         {shake_open, shake_close, done, busy}, {e_open, e_close, e_done, e_busy});
            end
            if (done === 1'b1) ndone++;
        end
        total++;
        if (ndone != 1) begin bad++; $display("FAIL reset_mid_done got=%0d exp=1", ndone); end
    endtask

    task automatic test_random();
        repeat (4000) begin
            start     = ($urandom_range(0, 39) == 0);
            stop      = ($urandom_range(0, 149) == 0);
            burst_cnt = 4'($urandom_range(0, 3));
            long_sel  = 1'($urandom_range(0, 1));
            s_rst_n   = ($urandom_range(0, 999) != 0);
            step();
            total++;
            if ({shake_open, shake_close, done, busy} !== {e_open, e_close, e_done, e_busy}) begin
                bad++;
                $display("FAIL random_trace cyc=%0d got=%b exp=%b", cyc,
                         {shake_open, shake_close, done, busy}, {e_open, e_close, e_done, e_busy});
            end
            total++;
            if (shake_open === 1'b1 && shake_close === 1'b1) begin
                bad++;
                $display("FAIL random_exclusive cyc=%0d got=11 exp=not both", cyc);
            end
        end
        start = 0; stop = 0; s_rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_two_bursts();
        test_zero_burst();
        test_start_stop_same();
        test_stop();
        test_retrigger();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
